ex_result_stage: RTL and testbench
==================================

// Module: ex_result_stage
// PURPOSE
//  Execute-stage back end, directly downstream of the 16-bit CLA add/sub.
//  - Takes the raw sum, overflow flag and other ALU result, and applies ADD/SUB saturation.
//  - Maintains the Z/V/N flag register and evaluates branch conditions.
//  - Registers the result plus writeback control into the EX/MEM pipeline register, with stall and flush.
// PARAMETERS
//  W         16   datapath width; saturation limits are derived from it
//  RW        4    register-index width
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous active-low reset
//  stall      in   1   hold all state this cycle
//  flush      in   1   insert bubble into EX/MEM
//  in_valid   in   1   EX holds a real instruction
//  op         in   4   opcode (cpu_pkg::opcode_t)
//  sum        in   W   adder sum
//  ovfl       in   1   adder signed overflow
//  a_msb      in   1   A[W-1] of adder operand; gives the saturation direction
//  alu_in     in   W   result of the non-adder ALU ops (XOR/SLL/SRA/ROR/...)
//  rd         in   RW  destination register
//  reg_wr     in   1   instruction writes rd
//  cond       in   3   branch condition code (cpu_pkg::cond_t)
//  mem_valid  out  1   EX/MEM valid
//  mem_result out  W   EX/MEM result
//  mem_rd     out  RW  EX/MEM destination
//  mem_reg_wr out  1   EX/MEM write enable (0 when !mem_valid)
//  flag_z/v/n out  1   architectural flags (registered)
//  br_taken   out  1   combinational: cond satisfied by the registered flags
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all outputs 0; flags Z=V=N=0. Reset overrides stall.
//  - Saturation (combinational), for op ADD/SUB only:
//      ovfl=1 & a_msb=0 -> 16'h7FFF
//      ovfl=1 & a_msb=1 -> 16'h8000
//      otherwise        -> sum
//    Every other op uses alu_in. The result has no width growth.
//  - Latency: 1 cycle, input to mem_* outputs.
//  - Priority per edge: reset > flush > stall > normal load.
//      flush: mem_valid=0, mem_reg_wr=0, mem_result/mem_rd=0; flags unchanged.
//      stall (no flush): every register holds its value.
//      normal: mem_* <= inputs; mem_reg_wr <= reg_wr & in_valid.
//  - Flag update happens only on a normal load with in_valid=1:
//      ADD/SUB: Z=(res==0), V=ovfl, N=res[W-1]. Z and N use the saturated result.
//      XOR/SLL/SRA/ROR: Z=(res==0); V and N hold.
//      all other ops: no flag change.
//  - br_taken uses the current registered flags, so a flag-setting instruction affects a branch one cycle later:
//      000 NE   !Z
//      001 EQ   Z
//      010 GT   !Z&!N
//      011 LT   N
//      100 GTE  Z|(!Z&!N)
//      101 LTE  N|Z
//      110 OV   V
//      111 UNC  1
//  - Stall and flush together: flush wins (bubble inserted, flags held).
// STRUCTURE
//  - cpu_pkg holds:
//      opcode_t enum: ADD=0, SUB=1, XOR=2, RED=3, SLL=4, SRA=5, ROR=6, PADDSB=7, LW=8, SW=9, LLB=A, LHB=B, B=C, BR=D, PCS=E, HLT=F
//      cond_t enum: NE..UNC
//      SAT_MAX/SAT_MIN constants
//      sets_zvn()/sets_z() helper functions
//  - Sub-module flag_reg: the Z/V/N flops, the update-enable logic and the cond_eval mux for br_taken.
//  - Top level: saturation mux plus the EX/MEM register.
// TESTING
//  1. Hold rst_n=0 for 2 clk with in_valid=1, op=ADD -> all outputs 0, Z=V=N=0, br_taken(cond=EQ)=0.
//  2. ADD sum=16'h8001, ovfl=1, a_msb=0 -> next cycle mem_result=16'h7FFF, V=1, N=0, Z=0; cond=OV -> br_taken=1.
//  3. SUB sum=16'h0000, ovfl=0, reg_wr=1, rd=5 -> mem_result=0, mem_rd=5, mem_reg_wr=1, Z=1, N=0; then XOR alu_in=16'h0010 -> Z=0, V and N unchanged.
//  4. stall=1 for 3 cycles while inputs toggle -> mem_* and flags constant. Then stall=1 & flush=1 -> mem_valid=0, mem_reg_wr=0, flags held.
//  5. LW with alu_in=16'h1234, in_valid=1 -> mem_result=16'h1234, flags unchanged. Same op with in_valid=0 -> mem_reg_wr=0, no flag change.
//  6. ADD sum=16'h7FFE, ovfl=1, a_msb=1 -> mem_result=16'h8000, N=1, V=1; cond LT=1, LTE=1, GT=0, UNC=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: opcodes, branch conditions, saturation limits and flag-update helpers.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    COND_NE  = 3'b000,
    COND_EQ  = 3'b001,
    COND_GT  = 3'b010,
    COND_LT  = 3'b011,
    COND_GTE = 3'b100,
    COND_LTE = 3'b101,
    COND_OV  = 3'b110,
    COND_UNC = 3'b111
  } cond_t;

  // Adder ops: saturate and update all three flags.
  function automatic logic sets_zvn(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Logic/shift ops: update Z only.
  function automatic logic sets_z(input opcode_t op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Z/V/N flag register with update gating, plus the branch-condition evaluator.
module flag_reg
  import cpu_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [3:0]   op,
  input  logic [W-1:0] res,
  input  logic         ovfl,
  input  logic [2:0]   cond,
  output logic         flag_z,
  output logic         flag_v,
  output logic         flag_n,
  output logic         br_taken
);

  opcode_t op_e;
  cond_t   cond_e;
  logic    upd_c;
  logic    res_zero_c;

  always_comb begin
    op_e       = opcode_t'(op);
    cond_e     = cond_t'(cond);
    upd_c      = !flush && !stall && in_valid;
    res_zero_c = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (upd_c) begin
      if (sets_zvn(op_e)) begin
        flag_z <= res_zero_c;
        flag_v <= ovfl;
        flag_n <= res[W-1];
      end else if (sets_z(op_e)) begin
        flag_z <= res_zero_c;
      end
    end
  end

  // Branch decision from the architectural (registered) flags only.
  always_comb begin
    br_taken = 1'b0;
    unique case (cond_e)
      COND_NE:  br_taken = !flag_z;
      COND_EQ:  br_taken = flag_z;
      COND_GT:  br_taken = !flag_z && !flag_n;
      COND_LT:  br_taken = flag_n;
      COND_GTE: br_taken = flag_z || (!flag_z && !flag_n);
      COND_LTE: br_taken = flag_n || flag_z;
      COND_OV:  br_taken = flag_v;
      COND_UNC: br_taken = 1'b1;
      default:  br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage back end: ADD/SUB saturation, flag register and the EX/MEM pipeline register.
module ex_result_stage
  import cpu_pkg::*;
#(
  parameter int unsigned W  = DATA_W,
  parameter int unsigned RW = REG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [3:0]    op,
  input  logic [W-1:0]  sum,
  input  logic          ovfl,
  input  logic          a_msb,
  input  logic [W-1:0]  alu_in,
  input  logic [RW-1:0] rd,
  input  logic          reg_wr,
  input  logic [2:0]    cond,
  output logic          mem_valid,
  output logic [W-1:0]  mem_result,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_wr,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          br_taken
);

  localparam logic [W-1:0] SAT_MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN_W = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] res_c;

  // Overflow direction follows the sign of operand A.
  always_comb begin
    res_c = alu_in;
    if (sets_zvn(opcode_t'(op))) begin
      res_c = sum;
      if (ovfl) res_c = a_msb ? SAT_MIN_W : SAT_MAX_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_rd     <= '0;
      mem_reg_wr <= 1'b0;
    end else if (!stall) begin
      mem_valid  <= in_valid;
      mem_result <= res_c;
      mem_rd     <= rd;
      mem_reg_wr <= reg_wr & in_valid;
    end
  end

  flag_reg #(.W(W)) u_flag_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .op       (op),
    .res      (res_c),
    .ovfl     (ovfl),
    .cond     (cond),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_taken (br_taken)
  );

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage with hand-computed expectations.
module tb_ex_result_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid, ovfl, a_msb, reg_wr;
  logic [3:0]  op;
  logic [15:0] sum, alu_in;
  logic [3:0]  rd;
  logic [2:0]  cond;
  logic        mem_valid, mem_reg_wr, flag_z, flag_v, flag_n, br_taken;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .op         (op),
    .sum        (sum),
    .ovfl       (ovfl),
    .a_msb      (a_msb),
    .alu_in     (alu_in),
    .rd         (rd),
    .reg_wr     (reg_wr),
    .cond       (cond),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .mem_reg_wr (mem_reg_wr),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .br_taken   (br_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] s, input logic ov,
                       input logic am, input logic [15:0] al, input logic [3:0] r,
                       input logic wr, input logic v);
    op = o; sum = s; ovfl = ov; a_msb = am; alu_in = al; rd = r; reg_wr = wr; in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag, input logic v, input logic [15:0] res,
                           input logic [3:0] r, input logic wr);
    check({tag, ".valid"},  32'(mem_valid),  32'(v));
    check({tag, ".result"}, 32'(mem_result), 32'(res));
    check({tag, ".rd"},     32'(mem_rd),     32'(r));
    check({tag, ".reg_wr"}, 32'(mem_reg_wr), 32'(wr));
  endtask

  task automatic check_flags(input string tag, input logic [2:0] zvn);
    check({tag, ".zvn"}, 32'({flag_z, flag_v, flag_n}), 32'(zvn));
  endtask

  task automatic check_br(input string tag, input logic [2:0] c, input logic exp);
    cond = c;
    #1;
    check({tag, ".br"}, 32'(br_taken), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cond = COND_EQ;
    drive(OP_ADD, 16'h1234, 1'b1, 1'b0, 16'h5555, 4'd9, 1'b1, 1'b1);

    // Reset
    step(); step();
    check_mem("reset", 1'b0, 16'h0000, 4'd0, 1'b0);
    check_flags("reset", 3'b000);
    check_br("reset_eq", COND_EQ, 1'b0);
    check_br("reset_ne", COND_NE, 1'b1);

    // Positive overflow saturates high
    rst_n = 1'b1;
    drive(OP_ADD, 16'h8001, 1'b1, 1'b0, 16'h0000, 4'd3, 1'b1, 1'b1);
    step();
    check_mem("add_sat_pos", 1'b1, 16'h7FFF, 4'd3, 1'b1);
    check_flags("add_sat_pos", 3'b010);
    check_br("add_sat_pos_ov", COND_OV, 1'b1);

    // SUB to zero, then XOR touches only Z
    drive(OP_SUB, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 4'd5, 1'b1, 1'b1);
    step();
    check_mem("sub_zero", 1'b1, 16'h0000, 4'd5, 1'b1);
    check_flags("sub_zero", 3'b100);
    check_br("sub_zero_eq", COND_EQ, 1'b1);
    drive(OP_XOR, 16'h8000, 1'b1, 1'b1, 16'h0010, 4'd7, 1'b1, 1'b1);
    step();
    check_mem("xor", 1'b1, 16'h0010, 4'd7, 1'b1);
    check_flags("xor", 3'b000);

    // Stall holds everything while inputs toggle
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(OP_ADD, 16'h0000, 1'b0, 1'b0, 16'(i), 4'(i + 1), 1'b0, 1'b1);
      step();
      check_mem("stall", 1'b1, 16'h0010, 4'd7, 1'b1);
      check_flags("stall", 3'b000);
    end

    // Flush beats stall; flags hold
    flush = 1'b1;
    step();
    check_mem("flush", 1'b0, 16'h0000, 4'd0, 1'b0);
    check_flags("flush", 3'b000);
    stall = 1'b0; flush = 1'b0;

    // Set Z, then LW must not disturb it
    drive(OP_SUB, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b1);
    step();
    check_flags("sub_z", 3'b100);
    drive(OP_LW, 16'h0000, 1'b0, 1'b0, 16'h1234, 4'd2, 1'b1, 1'b1);
    step();
    check_mem("lw", 1'b1, 16'h1234, 4'd2, 1'b1);
    check_flags("lw", 3'b100);
    drive(OP_LW, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd4, 1'b1, 1'b0);
    step();
    check_mem("lw_inv", 1'b0, 16'h0000, 4'd4, 1'b0);
    check_flags("lw_inv", 3'b100);
    drive(OP_XOR, 16'h0000, 1'b0, 1'b0, 16'h0005, 4'd4, 1'b1, 1'b0);
    step();
    check_flags("xor_inv", 3'b100);

    // Negative overflow saturates low
    drive(OP_ADD, 16'h7FFE, 1'b1, 1'b1, 16'h0000, 4'd6, 1'b1, 1'b1);
    step();
    check_mem("add_sat_neg", 1'b1, 16'h8000, 4'd6, 1'b1);
    check_flags("add_sat_neg", 3'b011);
    check_br("neg_lt",  COND_LT,  1'b1);
    check_br("neg_lte", COND_LTE, 1'b1);
    check_br("neg_gt",  COND_GT,  1'b0);
    check_br("neg_gte", COND_GTE, 1'b0);
    check_br("neg_unc", COND_UNC, 1'b1);
    check_br("neg_ov",  COND_OV,  1'b1);

    // Zero via logic op keeps V and N
    drive(OP_XOR, 16'h1111, 1'b0, 1'b0, 16'h0000, 4'd8, 1'b0, 1'b1);
    step();
    check_mem("xor_zero", 1'b1, 16'h0000, 4'd8, 1'b0);
    check_flags("xor_zero", 3'b111);
    check_br("z_gte", COND_GTE, 1'b1);
    check_br("z_ne",  COND_NE,  1'b0);

    // Reset overrides stall
    rst_n = 1'b0; stall = 1'b1;
    step();
    check_mem("reset_stall", 1'b0, 16'h0000, 4'd0, 1'b0);
    check_flags("reset_stall", 3'b000);
    rst_n = 1'b1; stall = 1'b0;

    // Plain ADD, no overflow: a_msb ignored
    drive(OP_ADD, 16'h1234, 1'b0, 1'b1, 16'hAAAA, 4'd10, 1'b1, 1'b1);
    step();
    check_mem("add_plain", 1'b1, 16'h1234, 4'd10, 1'b1);
    check_flags("add_plain", 3'b000);
    check_br("plain_gt", COND_GT, 1'b1);
    check_br("plain_lt", COND_LT, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
